// File: rtl/xdma_pkg.sv
// Shared XDMA types and constants for the write-side burst reshaper.
package xdma_pkg;

    localparam int DataWidth     = 512;
    localparam int AddrWidth     = 64;
    localparam int LenWidth      = 32;
    localparam int IdxWidth      = 5;
    localparam int MaxBurstBeats = 256;
    localparam int BytesPerBeat  = DataWidth / 8;
    localparam int PageBytes     = 4096;
    localparam int BeatOffW      = $clog2(BytesPerBeat);
    localparam int PageOffW      = $clog2(PageBytes);
    localparam int BeatsW        = 9;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [LenWidth-1:0]  len_t;
    typedef logic [IdxWidth-1:0]  xdma_req_idx_t;

    typedef struct packed {
        logic [7:0] dma_id;
        logic       dma_type;
        addr_t      remote_addr;
        len_t       dma_length;
        logic       ready_to_transfer;
    } xdma_req_desc_t;

    typedef struct packed {
        logic [7:0]    dma_id;
        logic          dma_type;
        xdma_req_idx_t idx;
        addr_t         addr;
        logic [7:0]    len;
    } xdma_req_aw_desc_t;

    typedef struct packed {
        logic [7:0]        dma_id;
        xdma_req_idx_t     idx;
        logic [BeatsW-1:0] num_beats;
        logic              is_first;
        logic              is_last;
    } xdma_req_w_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SPLIT     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } splitter_state_e;

endpackage

// File: rtl/xdma_burst_len_calc.sv
// Combinational burst sizing: min(remaining beats, beats left in the 4 KiB page, AXI cap).
module xdma_burst_len_calc
    import xdma_pkg::*;
(
    input  logic [PageOffW-BeatOffW-1:0] beat_in_page_i,
    input  len_t                         remaining_i,
    output logic [BeatsW-1:0]            beats_o
);

    localparam int PageBeats = PageBytes / BytesPerBeat;

    logic [BeatsW-1:0] to_page;
    logic [BeatsW-1:0] capped;

    always_comb begin
        to_page = BeatsW'(PageBeats) - BeatsW'(beat_in_page_i);
        capped  = (to_page < BeatsW'(MaxBurstBeats)) ? to_page : BeatsW'(MaxBurstBeats);
        beats_o = (remaining_i < len_t'(capped)) ? BeatsW'(remaining_i) : capped;
    end

endmodule

// File: rtl/xdma_write_burst_splitter.sv
// Splits one write request into AXI-legal AW/W descriptor pairs, then waits for done.
// Optional checks: define XDMA_RESHAPER_ASSERTIONS_EN.
module xdma_write_burst_splitter
    import xdma_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_req_done_i,
    input  xdma_req_desc_t    write_req_desc_i,
    input  xdma_req_idx_t     write_req_idx_i,
    input  logic              write_req_desc_valid_i,
    output xdma_req_aw_desc_t write_req_aw_desc_o,
    output xdma_req_w_desc_t  write_req_w_desc_o,
    output logic              write_req_desc_valid_o,
    input  logic              write_req_desc_ready_i
);

    splitter_state_e   state_q;
    logic              valid_in_q;
    logic              valid_q;
    addr_t             addr_q;
    len_t              rem_q;
    logic [7:0]        dma_id_q;
    logic              dma_type_q;
    xdma_req_idx_t     idx_q;
    xdma_req_aw_desc_t aw_q;
    xdma_req_w_desc_t  w_q;

    logic              accept;
    logic              handshake;
    addr_t             calc_addr;
    len_t              calc_rem;
    logic [BeatsW-1:0] beats;
    xdma_req_aw_desc_t aw_d;
    xdma_req_w_desc_t  w_d;
    addr_t             addr_d;
    len_t              rem_d;

    logic unused_desc_bits;
    assign unused_desc_bits = ^{write_req_desc_i.ready_to_transfer,
                                write_req_desc_i.remote_addr[BeatOffW-1:0]};

    // addr_q/rem_q always hold the start of the burst after the one being presented,
    // so the next pair can be registered on the same edge as the handshake.
    always_comb begin
        accept    = (state_q == ST_IDLE) && write_req_desc_valid_i && !valid_in_q;
        handshake = valid_q && write_req_desc_ready_i;
        if (state_q == ST_IDLE) begin
            calc_addr = {write_req_desc_i.remote_addr[AddrWidth-1:BeatOffW], {BeatOffW{1'b0}}};
            calc_rem  = write_req_desc_i.dma_length;
        end else begin
            calc_addr = addr_q;
            calc_rem  = rem_q;
        end
    end

    xdma_burst_len_calc u_len_calc (
        .beat_in_page_i (calc_addr[PageOffW-1:BeatOffW]),
        .remaining_i    (calc_rem),
        .beats_o        (beats)
    );

    always_comb begin
        aw_d          = '0;
        w_d           = '0;
        aw_d.dma_id   = (state_q == ST_IDLE) ? write_req_desc_i.dma_id   : dma_id_q;
        aw_d.dma_type = (state_q == ST_IDLE) ? write_req_desc_i.dma_type : dma_type_q;
        aw_d.idx      = (state_q == ST_IDLE) ? write_req_idx_i           : idx_q;
        aw_d.addr     = calc_addr;
        aw_d.len      = 8'(beats - BeatsW'(1));
        w_d.dma_id    = aw_d.dma_id;
        w_d.idx       = aw_d.idx;
        w_d.num_beats = beats;
        w_d.is_first  = (state_q == ST_IDLE);
        w_d.is_last   = (len_t'(beats) == calc_rem);
        addr_d        = calc_addr + (addr_t'(beats) << BeatOffW);
        rem_d         = calc_rem - len_t'(beats);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            valid_in_q <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            dma_id_q   <= '0;
            dma_type_q <= 1'b0;
            idx_q      <= '0;
            aw_q       <= '0;
            w_q        <= '0;
        end else begin
            valid_in_q <= write_req_desc_valid_i;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dma_id_q   <= write_req_desc_i.dma_id;
                        dma_type_q <= write_req_desc_i.dma_type;
                        idx_q      <= write_req_idx_i;
                        if (write_req_desc_i.dma_length != '0) begin
                            aw_q    <= aw_d;
                            w_q     <= w_d;
                            valid_q <= 1'b1;
                            addr_q  <= addr_d;
                            rem_q   <= rem_d;
                            state_q <= ST_SPLIT;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (handshake) begin
                        if (w_q.is_last) begin
                            valid_q <= 1'b0;
                            state_q <= ST_WAIT_DONE;
                        end else begin
                            aw_q   <= aw_d;
                            w_q    <= w_d;
                            addr_q <= addr_d;
                            rem_q  <= rem_d;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (write_req_done_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign write_req_aw_desc_o    = aw_q;
    assign write_req_w_desc_o     = w_q;
    assign write_req_desc_valid_o = valid_q;

`ifdef XDMA_RESHAPER_ASSERTIONS_EN
    len_t beat_sum_q;
    len_t total_len_q;

    a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_q && !write_req_desc_ready_i) |=> (valid_q && $stable(aw_q) && $stable(w_q)));

    a_len_match: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_q |-> ({1'b0, aw_q.len} + BeatsW'(1) == w_q.num_beats));

    a_no_4k_cross: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_q |-> (int'(aw_q.addr[PageOffW-1:0]) + int'(w_q.num_beats) * BytesPerBeat <= PageBytes));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_sum_q  <= '0;
            total_len_q <= '0;
        end else begin
            if (accept) begin
                beat_sum_q  <= '0;
                total_len_q <= write_req_desc_i.dma_length;
            end else if (handshake) begin
                beat_sum_q <= beat_sum_q + len_t'(w_q.num_beats);
                if (w_q.is_last) begin
                    a_beat_sum: assert (beat_sum_q + len_t'(w_q.num_beats) == total_len_q)
                        else $error("beat sum %0d differs from length %0d",
                                    beat_sum_q + len_t'(w_q.num_beats), total_len_q);
                end
            end
            if (write_req_done_i && state_q != ST_WAIT_DONE) begin
                $warning("done pulse outside WAIT_DONE ignored");
            end
        end
    end
`endif

endmodule

// File: tb/tb_xdma_write_burst_splitter.sv
// Randomised bench for xdma_write_burst_splitter against a queue-based burst model.
module tb_xdma_write_burst_splitter;
    import xdma_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              done_i = 1'b0;
    xdma_req_desc_t    desc_i = '0;
    xdma_req_idx_t     idx_i = '0;
    logic              valid_i = 1'b0;
    xdma_req_aw_desc_t aw_o;
    xdma_req_w_desc_t  w_o;
    logic              valid_o;
    logic              ready_i = 1'b0;

    always #5 clk = ~clk;

    xdma_write_burst_splitter dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .write_req_done_i       (done_i),
        .write_req_desc_i       (desc_i),
        .write_req_idx_i        (idx_i),
        .write_req_desc_valid_i (valid_i),
        .write_req_aw_desc_o    (aw_o),
        .write_req_w_desc_o     (w_o),
        .write_req_desc_valid_o (valid_o),
        .write_req_desc_ready_i (ready_i)
    );

    typedef struct {
        longint unsigned addr;
        int              beats;
        bit              first;
        bit              last;
        logic [7:0]      id;
        logic            typ;
        xdma_req_idx_t   idx;
    } burst_t;

    burst_t exp_q[$];
    burst_t pin_q[$];
    int     total = 0;
    int     bad = 0;
    int     rmode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: walk the request page by page with plain arithmetic.
    task automatic model_gen(input longint unsigned addr, input longint unsigned len,
                             input logic [7:0] id, input logic typ, input xdma_req_idx_t idx,
                             input bit to_pin);
        longint unsigned a;
        longint unsigned rem;
        int b;
        bit first;
        burst_t e;
        a = addr - (addr % 64);
        rem = len;
        first = 1;
        while (rem > 0) begin
            b = int'((4096 - (a % 4096)) / 64);
            if (b > 256) b = 256;
            if (rem < longint'(b)) b = int'(rem);
            e.addr = a; e.beats = b; e.first = first; e.last = (rem == longint'(b));
            e.id = id; e.typ = typ; e.idx = idx;
            if (to_pin) pin_q.push_back(e); else exp_q.push_back(e);
            a = a + longint'(b) * 64;
            rem = rem - longint'(b);
            first = 0;
        end
    endtask

    // Compare process: every cycle out of reset, valid_o must match a pending burst.
    initial begin
        burst_t e;
        xdma_req_aw_desc_t ea;
        xdma_req_w_desc_t ew;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                chk("valid_o", 128'(valid_o), 128'(exp_q.size() != 0));
                if (valid_o && exp_q.size() != 0) begin
                    e = exp_q[0];
                    ea.dma_id = e.id; ea.dma_type = e.typ; ea.idx = e.idx;
                    ea.addr = e.addr; ea.len = 8'(e.beats - 1);
                    ew.dma_id = e.id; ew.idx = e.idx; ew.num_beats = 9'(e.beats);
                    ew.is_first = e.first; ew.is_last = e.last;
                    chk("aw_desc", 128'(aw_o), 128'(ea));
                    chk("w_desc", 128'(w_o), 128'(ew));
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Ready driver: 0 always ready, 1 random, 2 five stall cycles after each handshake.
    initial begin
        bit hs;
        int stall;
        stall = 0;
        forever begin
            @(negedge clk);
            hs = valid_o && ready_i;
            @(posedge clk);
            #1;
            case (rmode)
                0: ready_i = 1'b1;
                1: ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (hs) stall = 0;
                    else if (stall < 5) stall++;
                    ready_i = (stall >= 5);
                end
            endcase
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input longint unsigned addr, input int unsigned len,
                             input logic [7:0] id, input logic typ, input xdma_req_idx_t idx);
        desc_i.dma_id = id; desc_i.dma_type = typ; desc_i.remote_addr = addr;
        desc_i.dma_length = len; desc_i.ready_to_transfer = 1'b1;
        idx_i = idx;
        valid_i = 1'b1;
        @(posedge clk);
        model_gen(addr, len, id, typ, idx, 0);
        #1;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            cyc(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d bursts left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        cyc(1);
        done_i = 1'b0;
    endtask

    task automatic run_req(input longint unsigned addr, input int unsigned len, input int mode);
        rmode = mode;
        start_req(addr, len, 8'($urandom), 1'($urandom), 5'($urandom));
        if (len != 0) begin
            drain(5000);
            pulse_done();
        end
        valid_i = 1'b0;
        cyc(1);
    endtask

    initial begin
        int exp4[5];
        longint unsigned ra;
        int unsigned rl;

        // Pin the model with hand-computed values.
        model_gen(64'h1010_0000, 100, 8'h0, 1'b0, 5'h0, 1);
        chk("pin1_count", 128'(pin_q.size()), 128'(2));
        if (pin_q.size() >= 2) begin
            chk("pin1_b0_addr", 128'(pin_q[0].addr), 128'(64'h1010_0000));
            chk("pin1_b0_beats", 128'(pin_q[0].beats), 128'(64));
            chk("pin1_b0_first", 128'(pin_q[0].first), 128'(1));
            chk("pin1_b1_addr", 128'(pin_q[1].addr), 128'(64'h1010_1000));
            chk("pin1_b1_beats", 128'(pin_q[1].beats), 128'(36));
            chk("pin1_b1_last", 128'(pin_q[1].last), 128'(1));
        end
        pin_q.delete();
        model_gen(64'h1010_0FC0, 3, 8'h0, 1'b0, 5'h0, 1);
        chk("pin3_count", 128'(pin_q.size()), 128'(2));
        if (pin_q.size() >= 2) begin
            chk("pin3_b0_beats", 128'(pin_q[0].beats), 128'(1));
            chk("pin3_b0_last", 128'(pin_q[0].last), 128'(0));
            chk("pin3_b1_addr", 128'(pin_q[1].addr), 128'(64'h1010_1000));
            chk("pin3_b1_beats", 128'(pin_q[1].beats), 128'(2));
        end
        pin_q.delete();
        exp4 = '{64, 64, 64, 64, 44};
        model_gen(64'h1010_0000, 300, 8'h0, 1'b0, 5'h0, 1);
        chk("pin4_count", 128'(pin_q.size()), 128'(5));
        for (int i = 0; i < 5 && i < pin_q.size(); i++)
            chk("pin4_beats", 128'(pin_q[i].beats), 128'(exp4[i]));
        pin_q.delete();
        model_gen(64'hFFFF_FFFF_FFFF_FF80, 5, 8'h0, 1'b0, 5'h0, 1);
        chk("pinwrap_count", 128'(pin_q.size()), 128'(2));
        if (pin_q.size() >= 2) begin
            chk("pinwrap_b0_beats", 128'(pin_q[0].beats), 128'(2));
            chk("pinwrap_b1_addr", 128'(pin_q[1].addr), 128'(0));
            chk("pinwrap_b1_beats", 128'(pin_q[1].beats), 128'(3));
        end
        pin_q.delete();

        // Reset state.
        cyc(3);
        @(negedge clk);
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_aw", 128'(aw_o), 128'(0));
        chk("rst_w", 128'(w_o), 128'(0));
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cyc(1);

        // Two-burst split and page-edge split.
        run_req(64'h1010_0000, 100, 0);
        run_req(64'h1010_0FC0, 3, 0);

        // Valid held high after done is not re-issued.
        rmode = 0;
        start_req(64'h1010_0000, 100, 8'h21, 1'b1, 5'd3);
        drain(2000);
        pulse_done();
        cyc(6);
        valid_i = 1'b0;
        cyc(1);

        // Backpressure, with a stray done during the split.
        rmode = 2;
        start_req(64'h1010_0000, 300, 8'h42, 1'b0, 5'd7);
        cyc(3);
        pulse_done();
        drain(2000);
        pulse_done();
        valid_i = 1'b0;
        cyc(1);

        // Zero length: no burst, no done needed, immediately ready for the next request.
        rmode = 0;
        start_req(64'h3000_0000, 0, 8'h05, 1'b0, 5'd1);
        cyc(3);
        valid_i = 1'b0;
        cyc(1);
        run_req(64'h3000_0040, 7, 0);

        // Simultaneous done and rising valid in WAIT_DONE: request not taken.
        rmode = 0;
        start_req(64'h4000_0F00, 10, 8'h66, 1'b1, 5'd9);
        valid_i = 1'b0;
        drain(2000);
        valid_i = 1'b1;
        pulse_done();
        cyc(4);
        valid_i = 1'b0;
        cyc(1);
        run_req(64'h4000_0000, 20, 1);

        // Address wrap.
        run_req(64'hFFFF_FFFF_FFFF_FF80, 5, 1);

        // Reset mid-split.
        rmode = 2;
        start_req(64'h2000_0000, 300, 8'h77, 1'b0, 5'd2);
        cyc(8);
        rst_i = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        exp_q.delete();
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 128'(valid_o), 128'(0));
        chk("midrst_aw", 128'(aw_o), 128'(0));
        chk("midrst_w", 128'(w_o), 128'(0));
        @(posedge clk);
        #1;
        run_req(64'h2000_0000, 70, 0);

        // Randomised requests.
        for (int k = 0; k < 40; k++) begin
            ra = {32'($urandom), 32'($urandom)};
            case ($urandom_range(0, 3))
                0: rl = 0;
                1: rl = $urandom_range(1, 8);
                2: rl = $urandom_range(1, 600);
                default: rl = $urandom_range(256, 1100);
            endcase
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFC0 - 12'($urandom_range(0, 3) * 64);
            run_req(ra, rl, int'($urandom_range(0, 2)));
        end

        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
